// File: rtl/tinychip_pkg.sv
// Shared widths, requester ids and writeback request bundle
// for the register file write arbiter.
package tinychip_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 4;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request channels: ALU (req0) and load (req1),
// each a valid/ready handshake carrying address and data.
interface rf_write_arbiter_if;
  import tinychip_pkg::*;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready
  );

endinterface

// File: rtl/rf_write_arbiter_rr.sv
// Two-way round-robin arbiter; last_grant only moves on a grant,
// and reset leaves it at 1 so requester 0 wins first contention.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between ALU and load
// writeback; registered write port plus a combinational busy mask.
module rf_write_arbiter
  import tinychip_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  rf_write_arbiter_if.slave   wb,
  output logic [ADDR_W-1:0]   reg_w,
  output logic                do_write,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] busy_mask
);

  wb_req_t    req [2];
  logic [1:0] gnt;
  logic       en;

  assign req[REQ_ALU]  = '{wb.req0_valid, wb.req0_addr,
                           wb.req0_data};
  assign req[REQ_LOAD] = '{wb.req1_valid, wb.req1_addr,
                           wb.req1_data};

  assign en = reset & ~hold;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req[REQ_LOAD].valid, req[REQ_ALU].valid}),
    .en    (en),
    .gnt   (gnt)
  );

  assign wb.req0_ready = gnt[REQ_ALU];
  assign wb.req1_ready = gnt[REQ_LOAD];

  always_ff @(posedge clk) begin
    if (!reset) begin
      do_write   <= 1'b0;
      reg_w      <= '0;
      write_data <= '0;
    end else begin
      do_write <= |gnt;
      if (gnt[REQ_LOAD]) begin
        reg_w      <= req[REQ_LOAD].addr;
        write_data <= req[REQ_LOAD].data;
      end else if (gnt[REQ_ALU]) begin
        reg_w      <= req[REQ_ALU].addr;
        write_data <= req[REQ_ALU].data;
      end
    end
  end

  // Pending requests count as busy so hazards see them early
  always_comb begin
    busy_mask = '0;
    if (reset) begin
      if (do_write)
        busy_mask[reg_w] = 1'b1;
      if (req[REQ_ALU].valid)
        busy_mask[req[REQ_ALU].addr] = 1'b1;
      if (req[REQ_LOAD].valid)
        busy_mask[req[REQ_LOAD].addr] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a register file model.
// Inputs change 1ns after posedge; checks happen on negedge.
module tb_rf_write_arbiter;
  import tinychip_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                hold;
  logic [ADDR_W-1:0]   reg_w;
  logic                do_write;
  logic [DATA_W-1:0]   write_data;
  logic [NUM_REGS-1:0] busy_mask;
  logic [DATA_W-1:0]   rf [NUM_REGS];

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_a;
  logic [DATA_W-1:0] exp_d;
  logic p0 = 1'b0;
  logic p1 = 1'b0;

  rf_write_arbiter_if wb ();

  rf_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .wb         (wb),
    .reg_w      (reg_w),
    .do_write   (do_write),
    .write_data (write_data),
    .busy_mask  (busy_mask)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;

  // Register file commits only while out of reset
  always @(posedge clk)
    if (reset === 1'b1 && do_write === 1'b1)
      rf[reg_w] <= write_data;

  // A pending request must not withdraw before ready
  always @(negedge clk) begin
    if (reset === 1'b1 && p0)
      assert (wb.req0_valid === 1'b1) else begin
        errors++;
        $error("FAIL req0_drop obs=%b exp=1", wb.req0_valid);
      end
    if (reset === 1'b1 && p1)
      assert (wb.req1_valid === 1'b1) else begin
        errors++;
        $error("FAIL req1_drop obs=%b exp=1", wb.req1_valid);
      end
    p0 = (reset === 1'b1) && wb.req0_valid && !wb.req0_ready;
    p1 = (reset === 1'b1) && wb.req1_valid && !wb.req1_ready;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    hold  = 1'b0;
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 2'd1;
    wb.req0_data  = 8'h00;
    wb.req1_valid = 1'b1;
    wb.req1_addr  = 2'd2;
    wb.req1_data  = 8'h00;

    // Reset with both requesters valid
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_rdy0", wb.req0_ready, 0);
    chk("rst_rdy1", wb.req1_ready, 0);
    chk("rst_dw", do_write, 0);
    chk("rst_busy", busy_mask, 4'b0000);
    chk("rst_regw", reg_w, 0);
    chk("rst_wd", write_data, 0);

    // Single ALU request
    cyc();
    reset = 1'b1;
    wb.req1_valid = 1'b0;
    wb.req0_addr  = 2'd1;
    wb.req0_data  = 8'hAA;
    @(negedge clk);
    chk("s_rdy0", wb.req0_ready, 1);
    chk("s_rdy1", wb.req1_ready, 0);
    chk("s_busy0", busy_mask, 4'b0010);
    chk("s_dw0", do_write, 0);

    cyc();
    wb.req0_valid = 1'b0;
    wb.req1_valid = 1'b1;
    wb.req1_addr  = 2'd0;
    wb.req1_data  = 8'h33;
    @(negedge clk);
    chk("s_dw1", do_write, 1);
    chk("s_regw", reg_w, 1);
    chk("s_wd", write_data, 8'hAA);
    chk("s_busy1", busy_mask, 4'b0011);
    chk("l_rdy1", wb.req1_ready, 1);

    // Contention after load was last granted
    cyc();
    wb.req1_valid = 1'b0;
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 2'd2;
    wb.req0_data  = 8'h11;
    wb.req1_valid = 1'b1;
    wb.req1_addr  = 2'd3;
    wb.req1_data  = 8'h22;
    @(negedge clk);
    chk("c0_rdy0", wb.req0_ready, 1);
    chk("c0_rdy1", wb.req1_ready, 0);
    chk("l_regw", reg_w, 0);
    chk("l_wd", write_data, 8'h33);
    chk("c0_busy", busy_mask, 4'b1101);

    cyc();
    wb.req0_valid = 1'b0;
    @(negedge clk);
    chk("c1_rdy0", wb.req0_ready, 0);
    chk("c1_rdy1", wb.req1_ready, 1);
    chk("c1_dw", do_write, 1);
    chk("c1_regw", reg_w, 2);
    chk("c1_wd", write_data, 8'h11);
    chk("c1_busy", busy_mask, 4'b1100);

    // Fairness: both valid for six grants
    cyc();
    wb.req1_valid = 1'b0;
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 2'd1;
    wb.req0_data  = 8'h40;
    wb.req1_valid = 1'b1;
    wb.req1_addr  = 2'd2;
    wb.req1_data  = 8'h50;
    exp_a = 2'd3;
    exp_d = 8'h22;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("f%0d_rdy0", i), wb.req0_ready, (i % 2 == 0));
      chk($sformatf("f%0d_rdy1", i), wb.req1_ready, (i % 2 == 1));
      chk($sformatf("f%0d_dw", i), do_write, 1);
      chk($sformatf("f%0d_regw", i), reg_w, exp_a);
      chk($sformatf("f%0d_wd", i), write_data, exp_d);
      cyc();
      if (i % 2 == 0) begin
        exp_a = 2'd1;
        exp_d = wb.req0_data;
        wb.req0_data = wb.req0_data + 8'h01;
      end else begin
        exp_a = 2'd2;
        exp_d = wb.req1_data;
        wb.req1_data = wb.req1_data + 8'h01;
      end
    end

    // Hold while both valid
    hold = 1'b1;
    @(negedge clk);
    chk("h0_rdy0", wb.req0_ready, 0);
    chk("h0_rdy1", wb.req1_ready, 0);
    chk("h0_dw", do_write, 1);
    chk("h0_regw", reg_w, 2);
    chk("h0_wd", write_data, 8'h52);

    cyc();
    @(negedge clk);
    chk("h1_dw", do_write, 0);
    chk("h1_regw", reg_w, 2);
    chk("h1_wd", write_data, 8'h52);
    chk("h1_busy", busy_mask, 4'b0110);
    chk("h1_rdy0", wb.req0_ready, 0);

    cyc();
    hold = 1'b0;
    @(negedge clk);
    chk("h2_rdy0", wb.req0_ready, 1);
    chk("h2_rdy1", wb.req1_ready, 0);

    cyc();
    wb.req0_valid = 1'b0;
    @(negedge clk);
    chk("h3_rdy1", wb.req1_ready, 1);
    chk("h3_regw", reg_w, 1);
    chk("h3_wd", write_data, 8'h43);

    cyc();
    wb.req1_valid = 1'b0;
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 2'd2;
    wb.req0_data  = 8'h55;
    @(negedge clk);
    chk("r0_rdy0", wb.req0_ready, 1);
    chk("r0_regw", reg_w, 2);
    chk("r0_wd", write_data, 8'h53);

    // Load wins (ALU was last), then reset drops its write
    cyc();
    wb.req0_addr  = 2'd0;
    wb.req0_data  = 8'h66;
    wb.req1_valid = 1'b1;
    wb.req1_addr  = 2'd0;
    wb.req1_data  = 8'hFF;
    @(negedge clk);
    chk("r1_rdy1", wb.req1_ready, 1);
    chk("r1_rdy0", wb.req0_ready, 0);
    chk("r1_regw", reg_w, 2);
    chk("r1_wd", write_data, 8'h55);
    chk("r1_busy", busy_mask, 4'b0101);

    cyc();
    reset = 1'b0;
    wb.req1_valid = 1'b0;
    @(negedge clk);
    chk("r2_dw", do_write, 1);
    chk("r2_regw", reg_w, 0);
    chk("r2_wd", write_data, 8'hFF);
    chk("r2_rdy0", wb.req0_ready, 0);
    chk("r2_busy", busy_mask, 4'b0000);

    cyc();
    @(negedge clk);
    chk("r3_dw", do_write, 0);
    chk("r3_regw", reg_w, 0);
    chk("r3_wd", write_data, 0);
    chk("r3_rdy0", wb.req0_ready, 0);
    chk("r3_rf0", rf[0], 8'h33);

    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("r4_rdy0", wb.req0_ready, 1);
    chk("r4_rdy1", wb.req1_ready, 0);

    cyc();
    wb.req0_valid = 1'b0;
    @(negedge clk);
    chk("r5_dw", do_write, 1);
    chk("r5_regw", reg_w, 0);
    chk("r5_wd", write_data, 8'h66);
    chk("r5_busy", busy_mask, 4'b0001);

    cyc();
    @(negedge clk);
    chk("r6_dw", do_write, 0);
    chk("rf0", rf[0], 8'h66);
    chk("rf1", rf[1], 8'h43);
    chk("rf2", rf[2], 8'h55);
    chk("rf3", rf[3], 8'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
